// File: rtl/sequence_verifier.sv
// Defuse-code checker feeding the game controller's s_results input.
// Optional macro SEQ_STRIKES_EN allows three wrong attempts before a loss.
`timescale 1ns/1ps
module sequence_verifier #(
    parameter int                   SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*4-1:0] SEQ_VALUE   = 16'h3141,
    parameter int                   HOLD_CYCLES = 250,
    parameter int                   HOLD_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_current,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] s_results,
    output logic [2:0] seq_idx,
    output logic [1:0] strikes
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_WIN   = 3'd2;
    localparam logic [2:0] ST_LOSE  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] SC_AUTH    = 8'h00;
    localparam logic [7:0] SC_PLAY    = 8'h10;
    localparam logic [7:0] SC_TIMEOUT = 8'h12;

    localparam logic [3:0]        LAST_IDX  = 4'(SEQ_LEN - 1);
    localparam logic [3:0]        FULL_IDX  = 4'(SEQ_LEN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [1:0]        res_q, res_d;
    logic [3:0]        expected;
`ifdef SEQ_STRIKES_EN
    logic [1:0]        strk_q, strk_d;
`endif

    always_comb begin
        expected = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (idx_q == 4'(i)) expected = SEQ_VALUE[(SEQ_LEN-1-i)*4 +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef SEQ_STRIKES_EN
        strk_d  = strk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_current == SC_PLAY) begin
                    state_d = ST_ARMED;
                    idx_d   = '0;
`ifdef SEQ_STRIKES_EN
                    strk_d  = '0;
`endif
                end
            end
            ST_ARMED: begin
                if (s_current == SC_TIMEOUT) begin
                    state_d = ST_LOSE;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    if (key_code == expected) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_WIN;
                            idx_d   = FULL_IDX;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
`ifdef SEQ_STRIKES_EN
                        // a wrong key restarts the code; the third one loses the game
                        idx_d = '0;
                        if (strk_q != 2'd3) strk_d = strk_q + 2'd1;
                        if (strk_q == 2'd2) begin
                            state_d = ST_LOSE;
                            cnt_d   = '0;
                        end
`else
                        state_d = ST_LOSE;
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (s_current == SC_AUTH || s_current == SC_PLAY) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
`ifdef SEQ_STRIKES_EN
                    strk_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
`ifdef SEQ_STRIKES_EN
                strk_d  = '0;
`endif
            end
        endcase
    end

    always_comb begin
        case (state_d)
            ST_WIN:  res_d = 2'b01;
            ST_LOSE: res_d = 2'b10;
            ST_DONE: res_d = 2'b11;
            default: res_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            res_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

`ifdef SEQ_STRIKES_EN
    always_ff @(posedge clk) begin
        if (!rst) strk_q <= '0;
        else      strk_q <= strk_d;
    end
    assign strikes = strk_q;
`else
    assign strikes = 2'b00;
`endif

    // the 3-bit port cannot show 8; a full 8-digit code reports 7
    assign seq_idx   = (idx_q > 4'd7) ? 3'd7 : idx_q[2:0];
    assign s_results = res_q;

endmodule

// File: tb/tb_sequence_verifier.sv
// Randomized + directed bench for sequence_verifier against a digit-list reference model.
`timescale 1ns/1ps
module tb_sequence_verifier;

    localparam int          SEQ_LEN   = 4;
    localparam logic [15:0] SEQ_VALUE = 16'h3141;
    localparam int          HOLD      = 250;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_current = 8'h00;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [1:0] s_results;
    logic [2:0] seq_idx;
    logic [1:0] strikes;

    sequence_verifier #(
        .SEQ_LEN(SEQ_LEN),
        .SEQ_VALUE(SEQ_VALUE),
        .HOLD_CYCLES(HOLD),
        .HOLD_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_current(s_current),
        .key_valid(key_valid),
        .key_code(key_code),
        .s_results(s_results),
        .seq_idx(seq_idx),
        .strikes(strikes)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    string test_name = "";

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d at %0t", test_name, tag, obs, exp, $time);
    endtask

    // reference model: 0 waiting for game, 1 entering code, 2 showing result, 3 result over
    int m_mode = 0, m_res = 0, m_idx = 0, m_strk = 0, m_left = 0;

    function automatic int digit(input int pos);
        return int'((SEQ_VALUE >> (4 * (SEQ_LEN - 1 - pos))) & 16'hF);
    endfunction

    task automatic model_tick(input bit r, input int sc, input bit kv, input int kc);
        if (!r) begin
            m_mode = 0; m_res = 0; m_idx = 0; m_strk = 0;
        end else if (m_mode == 0) begin
            if (sc == 'h10) begin m_mode = 1; m_idx = 0; m_strk = 0; end
        end else if (m_mode == 1) begin
            if (sc == 'h12) begin
                m_mode = 2; m_res = 2; m_left = HOLD;
            end else if (kv) begin
                if (kc == digit(m_idx)) begin
                    m_idx++;
                    if (m_idx == SEQ_LEN) begin m_mode = 2; m_res = 1; m_left = HOLD; end
                end else begin
`ifdef SEQ_STRIKES_EN
                    m_idx = 0;
                    if (m_strk < 3) m_strk++;
                    if (m_strk == 3) begin m_mode = 2; m_res = 2; m_left = HOLD; end
`else
                    m_mode = 2; m_res = 2; m_left = HOLD;
`endif
                end
            end
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin m_mode = 3; m_res = 3; end
        end else begin
            if (sc == 'h00 || sc == 'h10) begin m_mode = 0; m_res = 0; m_idx = 0; m_strk = 0; end
        end
    endtask

    task automatic step(input bit r, input logic [7:0] sc, input bit kv, input logic [3:0] kc);
        rst = r; s_current = sc; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_tick(r, int'(sc), kv, int'(kc));
        #1;
        check("s_results", 32'(s_results), m_res);
        check("seq_idx", 32'(seq_idx), m_idx);
        check("strikes", 32'(strikes), m_strk);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 4'h0);
        step(1'b0, 8'h00, 1'b1, 4'h3);
    endtask

    task automatic idle_n(input int n, input logic [7:0] sc);
        for (int i = 0; i < n; i++) step(1'b1, sc, 1'b0, 4'h0);
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, 8'h10, 1'b1, kc);
    endtask

    int run01;
    logic [3:0] seq4 [6] = '{4'h9, 4'h3, 4'h1, 4'h8, 4'h3, 4'h8};

    initial begin
        test_name = "reset";
        do_reset();

        test_name = "win";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h1); key(4'h4); key(4'h1);
        run01 = (s_results == 2'b01) ? 1 : 0;
        for (int i = 0; i < HOLD + 5; i++) begin
            step(1'b1, 8'h20, 1'b0, 4'h0);
            if (s_results == 2'b01) run01++;
        end
        check("hold_len", run01, HOLD);
        step(1'b1, 8'h20, 1'b1, 4'h3);
        step(1'b1, 8'h00, 1'b0, 4'h0);

        test_name = "lose_key";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h7);
        idle_n(HOLD + 3, 8'h20);
        step(1'b1, 8'h00, 1'b0, 4'h0);

        test_name = "timeout";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h1);
        step(1'b1, 8'h12, 1'b1, 4'h4);
        idle_n(3, 8'h12);
        do_reset();

        test_name = "strikes";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        for (int i = 0; i < 6; i++) key(seq4[i]);
        idle_n(HOLD + 2, 8'h20);
        step(1'b1, 8'h00, 1'b0, 4'h0);

        test_name = "ignored_keys";
        step(1'b1, 8'h00, 1'b1, 4'h3);
        step(1'b1, 8'h00, 1'b1, 4'h1);
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h1); key(4'h4); key(4'h1);
        step(1'b1, 8'h20, 1'b1, 4'h9);
        idle_n(HOLD, 8'h20);
        step(1'b1, 8'h20, 1'b1, 4'h3);
        test_name = "done_rearm";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3);
        do_reset();

        test_name = "reset_mid_win";
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h1); key(4'h4); key(4'h1);
        idle_n(10, 8'h20);
        step(1'b0, 8'h20, 1'b0, 4'h0);
        step(1'b1, 8'h10, 1'b0, 4'h0);
        key(4'h3); key(4'h1); key(4'h4); key(4'h1);
        idle_n(HOLD + 2, 8'h20);
        step(1'b1, 8'h00, 1'b0, 4'h0);

        test_name = "random";
        for (int i = 0; i < 6000; i++) begin
            int unsigned p = $urandom_range(99);
            logic [7:0] sc;
            logic [3:0] kc;
            bit kv;
            if (p < 70)      sc = 8'h10;
            else if (p < 72) sc = 8'h12;
            else if (p < 85) sc = 8'h00;
            else if (p < 92) sc = 8'h20;
            else             sc = 8'h01;
            kv = ($urandom_range(99) < 35);
            if (m_mode == 1 && $urandom_range(99) < 75) kc = 4'(digit(m_idx));
            else kc = 4'($urandom_range(15));
            step(($urandom_range(199) != 0), sc, kv, kc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
